// File: rtl/speed_ctrl.sv
// =============================================================================
// speed_ctrl
// -----------------------------------------------------------------------------
// Upstream control stage for the game clock divider. Two raw pushbuttons are
// synchronized and debounced. Each clean press becomes a single-step change of
// the 2-bit speed code, which is held in a register and fed to the divider.
//
//   Code 2'b00 = fastest game tick, 2'b11 = slowest.
//   "Faster" decrements the code, "slower" increments it.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive clk cycles a button must hold a new level
//                    before it is accepted (legal range >= 2)
//   RESET_RATE       value of clk_rate after reset
//
// Ports:
//   clk         in   system clock, shared with the divider
//   rst_n       in   asynchronous active-low reset, release sampled on clk
//   btn_faster  in   raw bouncing pushbutton, active-high
//   btn_slower  in   raw bouncing pushbutton, active-high
//   clk_rate    out  registered speed code for the divider
//   rate_pulse  out  one-cycle strobe in the cycle clk_rate takes a new value
//   at_limit    out  registered, high when clk_rate is 2'b00 or 2'b11
//
// Build option:
//   SPEED_WRAP_EN    when defined, the code wraps around at either end
//                    (faster at 2'b00 gives 2'b11, slower at 2'b11 gives
//                    2'b00). When undefined, the code saturates.
// =============================================================================
module speed_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [1:0]  RESET_RATE      = 2'b10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_faster,
    input  logic       btn_slower,
    output logic [1:0] clk_rate,
    output logic       rate_pulse,
    output logic       at_limit
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    // The counter reaches this value on the last cycle of the hold window,
    // at which point the new level is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic RESET_AT_LIMIT = (RESET_RATE == 2'b00) || (RESET_RATE == 2'b11);

`ifdef SPEED_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    // Index 0 = faster, index 1 = slower.
    logic [1:0] btn_raw;
    logic [1:0] ev;

    assign btn_raw = {btn_slower, btn_faster};

    // -------------------------------------------------------------------------
    // Per-button synchronizer, debouncer and rising-edge detector.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < 2; i++) begin : g_btn
        logic             sync1;
        logic             s2;
        logic             stable;
        logic             stable_d;
        logic [CNT_W-1:0] cnt;

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before the edge; blocking here
        // would collapse the two synchronizer stages into one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1    <= 1'b0;
                s2       <= 1'b0;
                stable   <= 1'b0;
                stable_d <= 1'b0;
                cnt      <= '0;
            end else begin
                sync1    <= btn_raw[i];
                s2       <= sync1;
                stable_d <= stable;

                // Any single cycle of agreement restarts the hold window, so
                // only an uninterrupted run of DEBOUNCE_CYCLES differing
                // samples flips the accepted level.
                if (s2 == stable) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        // Press event: one cycle wide, rising edges only, so a held button
        // gives exactly one step and releasing it gives none.
        assign ev[i] = stable & ~stable_d;
    end

    // -------------------------------------------------------------------------
    // Rate update
    // -------------------------------------------------------------------------
    logic [1:0] next_rate;
    logic       next_pulse;

    // NOTE: every output of this block gets a default first; without it a
    // path that skips an assignment would infer a latch.
    always_comb begin
        next_rate  = clk_rate;
        next_pulse = 1'b0;

        // Simultaneous events fall into the default and cancel out. In wrap
        // mode the 2-bit arithmetic wraps naturally at either end.
        case (ev)
            2'b01: begin
                if (WRAP || (clk_rate != 2'b00)) begin
                    next_rate  = clk_rate - 2'd1;
                    next_pulse = 1'b1;
                end
            end
            2'b10: begin
                if (WRAP || (clk_rate != 2'b11)) begin
                    next_rate  = clk_rate + 2'd1;
                    next_pulse = 1'b1;
                end
            end
            default: begin
                next_rate  = clk_rate;
                next_pulse = 1'b0;
            end
        endcase
    end

    // All outputs come straight from flops so the divider's case decode
    // never sees a glitch. at_limit is derived from the next value so it
    // changes on the same edge as clk_rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_rate   <= RESET_RATE;
            rate_pulse <= 1'b0;
            at_limit   <= RESET_AT_LIMIT;
        end else begin
            clk_rate   <= next_rate;
            rate_pulse <= next_pulse;
            at_limit   <= (next_rate == 2'b00) || (next_rate == 2'b11);
        end
    end

endmodule

// File: doc/speed_ctrl.md
# speed_ctrl

Upstream control stage for the game clock divider. Debounces the two speed buttons, turns each clean press into a single-step change of the 2-bit `clk_rate` code, and holds that code in a register. The divider consumes `clk_rate` directly.

- Code 2'b00 is the fastest game tick and 2'b11 the slowest.
- "Faster" decrements the code; "slower" increments it.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive `clk` cycles an input must hold a new level before it is accepted (20 ms at 50 MHz). Legal range is ≥ 2.
- `RESET_RATE`, default 2'b10: value of `clk_rate` after reset. 2'b10 selects divider ratio 4.

Ports (clock and reset first):
- `clk` input 1: system clock, same clock as the divider.
- `rst_n` input 1: reset, asynchronous and active-low. All state is cleared on assertion; release is sampled on `clk`.
- `btn_faster` input 1: raw, asynchronous, bouncing pushbutton, active-high.
- `btn_slower` input 1: raw, asynchronous, bouncing pushbutton, active-high.
- `clk_rate` output 2: registered speed code for the divider.
- `rate_pulse` output 1: one-cycle strobe, high in the cycle `clk_rate` takes a new value.
- `at_limit` output 1: registered; high when `clk_rate` is 2'b00 or 2'b11.

## Operation
The following logic is instantiated once per button, identically:
- **Synchronizer.** A 2-flop synchronizer produces `s2`.
- **Debounce state.** Each button has a `stable` register and a counter of width `$clog2(DEBOUNCE_CYCLES)`.
  - If `s2 == stable`, the counter is cleared to 0.
  - Otherwise the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and `s2` still differs, `stable <= s2` and the counter is cleared.
  - Any single-cycle agreement with `stable` restarts the count, so glitches shorter than `DEBOUNCE_CYCLES` are rejected.
- **Press event.** A registered rising-edge detector on `stable` produces the event `ev_f` (faster) or `ev_s` (slower), each one cycle wide.
  - Falling edges produce no event.
  - Holding a button produces exactly one event; there is no auto-repeat.

Rate update logic:
- **Faster only.** `ev_f` alone with `clk_rate > 0`: `clk_rate <= clk_rate - 1`, and `rate_pulse` goes high.
- **Slower only.** `ev_s` alone with `clk_rate < 3`: `clk_rate <= clk_rate + 1`, and `rate_pulse` goes high.
- **At the limit.** An event at the limit leaves `clk_rate` unchanged and `rate_pulse` stays low. Wrap-around behaviour is covered under Configuration.
- **Simultaneous events.** `ev_f` and `ev_s` in the same cycle cancel: no change and no pulse.
- **`at_limit`.** Updated on the same edge as `clk_rate`, from the next value of `clk_rate`.

## Timing
Reset values (while `rst_n` = 0):
- `clk_rate` = `RESET_RATE`.
- `rate_pulse` = 0.
- `at_limit` = (`RESET_RATE` is 2'b00 or 2'b11).
- Synchronizers, `stable` registers, counters and edge registers = 0.

Cycle-level behaviour:
- **Press latency.** A button is held steady high starting at edge 0, where `s2` first samples it.
  - `stable` rises at edge 0 + `DEBOUNCE_CYCLES`.
  - The event is generated combinationally from `stable` and its delayed copy.
  - `clk_rate` and `rate_pulse` update at edge `DEBOUNCE_CYCLES` + 1.
  - The total from the raw input is therefore `DEBOUNCE_CYCLES` + 3 edges, including the 2 synchronizer edges.
- **Release.** Release takes the same `DEBOUNCE_CYCLES` to clear `stable` and has no effect on outputs.
- **Pulse width.** `rate_pulse` is exactly 1 cycle wide. Two accepted presses are at least `2*DEBOUNCE_CYCLES` cycles apart.
- **Reset mid-press.** Reset asserted mid-debounce or mid-press discards the press. A button still held at reset release is seen as a new press after the full debounce.
- **Glitch-free output.** `clk_rate` changes only on `clk` edges and never glitches, which the divider's case decode relies on.

## Configuration
- `SPEED_WRAP_EN` defined: limits wrap around.
  - Faster at 2'b00 gives 2'b11; slower at 2'b11 gives 2'b00.
  - `rate_pulse` fires on every single accepted event.
  - `at_limit` still reports codes 2'b00 and 2'b11.
- `SPEED_WRAP_EN` undefined (default): saturating behaviour as described under Operation.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `RESET_RATE` = 2'b10.
- **Reset.** Assert `rst_n` = 0 asynchronously mid-cycle → `clk_rate` = 2'b10, `rate_pulse` = 0, `at_limit` = 0 immediately, with no clock edge needed.
- **Clean press.** Hold `btn_slower` high for 20 cycles → `clk_rate` becomes 2'b11 exactly 7 edges after the input rises, with a single 1-cycle `rate_pulse` and `at_limit` = 1. There is no further change while held.
- **Bounce rejection.** Toggle `btn_faster` high 3 cycles, low 1, high 2, low 1 → no change. Then hold high 10 cycles → `clk_rate` changes 2'b10 → 2'b01, with exactly one pulse.
- **Saturation.** From 2'b00, press `btn_faster` → no change, no pulse.
  - With `SPEED_WRAP_EN` defined, the same stimulus gives 2'b11 plus one pulse.
- **Simultaneous press.** Raise both buttons on the same cycle and hold them 10 cycles → `clk_rate` stays 2'b10 and `rate_pulse` never asserts.
- **Reset during debounce.** Assert `rst_n` low for 1 cycle while `btn_slower` has been high 2 cycles, keeping the button held → `clk_rate` goes to 2'b11 7 edges after reset release, not earlier.
